// File: rtl/parallel_interface_pkg.sv
// parallel_interface_pkg: shared widths, strobe bundle and reset values for the parallel bus slave.
package parallel_interface_pkg;
    localparam int PI_DATA_W = 16;
    localparam int PI_ADDR_W = 8;
    localparam logic [PI_DATA_W-1:0] MEM_RST = '0;
    typedef struct packed {
        logic cs_n;
        logic rd_n;
        logic wr_n;
    } strobe_t;
    localparam strobe_t STROBE_IDLE = 3'b111;
endpackage

// File: rtl/parallel_interface_if.sv
// parallel_interface_if: processor-style control strobes and address of the external bus.
interface parallel_interface_if import parallel_interface_pkg::*; #(
    parameter int ADDR_W = PI_ADDR_W
);
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic [ADDR_W-1:0] addr;
    modport master (output cs_n, rd_n, wr_n, addr);
    modport slave (input cs_n, rd_n, wr_n, addr);
endinterface

// File: rtl/parallel_interface_bus_sync.sv
// bus_sync: two-flop synchronizer with a per-bit reset value.
module bus_sync #(
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q, s2_q;
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end
    assign q_o = s2_q;
endmodule

// File: rtl/parallel_interface.sv
// parallel_interface: async parallel-bus slave bridging strobes into an sclk register file.
// Optional BUS_ERR_FLAG_EN adds bus_err, a one-cycle pulse when rd_n and wr_n overlap under cs_n.
module parallel_interface import parallel_interface_pkg::*; #(
    parameter int DATA_W = PI_DATA_W,
    parameter int ADDR_W = PI_ADDR_W
) (
    input  logic              sclk,
    input  logic              rst_n,
    parallel_interface_if.slave bus,
    inout  wire  [DATA_W-1:0] data
`ifdef BUS_ERR_FLAG_EN
    ,
    output logic              bus_err
`endif
);
    strobe_t str_s2;
    logic [ADDR_W+DATA_W-1:0] ad_s2;
    logic [ADDR_W-1:0] addr_s2;
    logic [DATA_W-1:0] data_s2;
    logic wr_s3_q;
    logic cap_q, cap_d;
    logic capture, commit, oe;
    logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d, rd_data_q;
    logic [ADDR_W-1:0] waddr_hold_q, waddr_hold_d;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    bus_sync #(.W(3), .RST_VAL(STROBE_IDLE)) u_strobe_sync (
        .sclk  (sclk),
        .rst_n (rst_n),
        .d_i   ({bus.cs_n, bus.rd_n, bus.wr_n}),
        .q_o   (str_s2)
    );

    bus_sync #(.W(ADDR_W+DATA_W), .RST_VAL('0)) u_ad_sync (
        .sclk  (sclk),
        .rst_n (rst_n),
        .d_i   ({bus.addr, data}),
        .q_o   (ad_s2)
    );

    assign addr_s2 = ad_s2[ADDR_W+DATA_W-1:DATA_W];
    assign data_s2 = ad_s2[DATA_W-1:0];

    // cap_q gates the commit so a strobe pulse never seen under cs_n cannot write
    always_comb begin
        capture      = !str_s2.cs_n && !str_s2.wr_n;
        commit       = str_s2.wr_n && !wr_s3_q && cap_q;
        cap_d        = capture ? 1'b1 : (commit ? 1'b0 : cap_q);
        wdata_hold_d = capture ? data_s2 : wdata_hold_q;
        waddr_hold_d = capture ? addr_s2 : waddr_hold_q;
        oe           = !str_s2.cs_n && !str_s2.rd_n && str_s2.wr_n;
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            wr_s3_q      <= 1'b1;
            cap_q        <= 1'b0;
            wdata_hold_q <= '0;
            waddr_hold_q <= '0;
            rd_data_q    <= '0;
            mem_q        <= '{default: DATA_W'(MEM_RST)};
        end else begin
            wr_s3_q      <= str_s2.wr_n;
            cap_q        <= cap_d;
            wdata_hold_q <= wdata_hold_d;
            waddr_hold_q <= waddr_hold_d;
            rd_data_q    <= mem_q[addr_s2];
            if (commit)
                mem_q[waddr_hold_q] <= wdata_hold_q;
        end
    end

    assign data = oe ? rd_data_q : 'z;

`ifdef BUS_ERR_FLAG_EN
    logic err_c, err_q, bus_err_q;
    assign err_c = !str_s2.cs_n && !str_s2.rd_n && !str_s2.wr_n;
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            err_q     <= err_c;
            bus_err_q <= err_c && !err_q;
        end
    end
    assign bus_err = bus_err_q;
`endif
endmodule

// File: tb/tb_parallel_interface.sv
// tb_parallel_interface: directed vector bench; a pull-up makes a released bus read 16'hFFFF.
module tb_parallel_interface;
    typedef struct {
        bit          wr;
        bit          cs_en;
        logic [7:0]  a;
        logic [15:0] d;
    } vec_t;

    logic sclk = 1'b0;
    logic rst_n;
    logic drv_en;
    logic [15:0] drv_val;
    wire  [15:0] data;
    int checks = 0;
    int failures = 0;
    vec_t v[$];

    parallel_interface_if bus();

    assign data = drv_en ? drv_val : 'z;
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (data[g]);
    end

`ifdef BUS_ERR_FLAG_EN
    logic bus_err;
`endif

    parallel_interface dut (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .bus     (bus),
        .data    (data)
`ifdef BUS_ERR_FLAG_EN
        ,
        .bus_err (bus_err)
`endif
    );

    always #10 sclk = ~sclk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wr_op(input logic [7:0] a, input logic [15:0] d, input bit cs_en);
        bus.cs_n = ~cs_en;
        bus.addr = a;
        drv_en   = 1'b1;
        drv_val  = d;
        cyc(2);
        bus.wr_n = 1'b0;
        cyc(2);
        chk("wr_no_slave_drive", 32'(data), 32'(d));
        cyc(2);
        bus.wr_n = 1'b1;
        cyc(2);
        drv_en   = 1'b0;
        bus.cs_n = 1'b1;
        cyc(3);
    endtask

    task automatic rd_op(input logic [7:0] a, input logic [15:0] exp);
        bus.cs_n = 1'b0;
        bus.addr = a;
        cyc(5);
        bus.rd_n = 1'b0;
        cyc(4);
        chk($sformatf("rd_addr_%0d", a), 32'(data), 32'(exp));
        bus.rd_n = 1'b1;
        cyc(1);
        chk("rd_hold_after_rise", 32'(data), 32'(exp));
        cyc(2);
        chk("rd_release", 32'(data), 32'hFFFF);
        bus.cs_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        int hi;
        int drove;
        rst_n    = 1'b0;
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.addr = '0;
        drv_en   = 1'b0;
        drv_val  = '0;
        for (int i = 0; i < 8; i++) v.push_back('{1'b1, 1'b1, 8'(i), 16'(i)});
        for (int i = 0; i < 8; i++) v.push_back('{1'b0, 1'b1, 8'(i), 16'(i)});
        v.push_back('{1'b0, 1'b1, 8'd8, 16'h0000});
        v.push_back('{1'b0, 1'b1, 8'd255, 16'h0000});
        v.push_back('{1'b1, 1'b0, 8'd3, 16'hABCD});
        v.push_back('{1'b0, 1'b1, 8'd3, 16'h0003});
        v.push_back('{1'b1, 1'b1, 8'd5, 16'h1234});
        v.push_back('{1'b0, 1'b1, 8'd5, 16'h1234});
        v.push_back('{1'b0, 1'b1, 8'd4, 16'h0004});

        cyc(10);
        chk("reset_bus_released", 32'(data), 32'hFFFF);
`ifdef BUS_ERR_FLAG_EN
        chk("reset_bus_err", 32'(bus_err), 32'h0);
`endif
        rst_n = 1'b1;
        cyc(3);

        foreach (v[k]) begin
            if (v[k].wr) wr_op(v[k].a, v[k].d, v[k].cs_en);
            else rd_op(v[k].a, v[k].d);
        end

        bus.cs_n = 1'b1;
        bus.rd_n = 1'b0;
        bus.addr = 8'd5;
        cyc(4);
        chk("idle_cs_high", 32'(data), 32'hFFFF);
        bus.rd_n = 1'b1;
        bus.cs_n = 1'b0;
        cyc(4);
        chk("idle_rd_high", 32'(data), 32'hFFFF);
        bus.cs_n = 1'b1;
        cyc(2);

        bus.cs_n = 1'b0;
        bus.addr = 8'd200;
        cyc(3);
        bus.rd_n = 1'b0;
        bus.wr_n = 1'b0;
        hi = 0;
        drove = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (data !== 16'hFFFF) drove++;
`ifdef BUS_ERR_FLAG_EN
            if (bus_err) hi++;
`endif
        end
        chk("overlap_bus_not_driven", 32'(drove), 32'd0);
`ifdef BUS_ERR_FLAG_EN
        chk("bus_err_one_pulse", 32'(hi), 32'd1);
`endif
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        cyc(2);
        bus.cs_n = 1'b1;
        cyc(3);
        rd_op(8'd200, 16'hFFFF);

        bus.cs_n = 1'b0;
        bus.addr = 8'd6;
        drv_en   = 1'b1;
        drv_val  = 16'hBEEF;
        cyc(2);
        bus.wr_n = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        bus.wr_n = 1'b1;
        cyc(3);
        drv_en   = 1'b0;
        bus.cs_n = 1'b1;
        cyc(2);
        chk("mid_reset_bus_released", 32'(data), 32'hFFFF);
`ifdef BUS_ERR_FLAG_EN
        chk("mid_reset_bus_err", 32'(bus_err), 32'h0);
`endif
        rst_n = 1'b1;
        cyc(3);
        rd_op(8'd6, 16'h0000);
        rd_op(8'd5, 16'h0000);
        rd_op(8'd0, 16'h0000);
        rd_op(8'd7, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
